// File: rtl/ct_vfdsu_pkg.sv
// Shared VFDSU types: writeback entry layout, result formats and NaN-box fill constants.
// Pure declarations, no logic and no backpressure.
package ct_vfdsu_pkg;

    localparam logic [31:0] NANBOX_S = 32'hFFFF_FFFF;
    localparam logic [47:0] NANBOX_H = 48'hFFFF_FFFF_FFFF;

    typedef struct packed {
        logic [63:0] data;
        logic [4:0]  expt;
        logic [6:0]  vreg;
        logic [4:0]  ereg;
        logic [6:0]  iid;
    } wb_entry_t;

    typedef enum logic [1:0] {
        FMT_DOUBLE = 2'd0,
        FMT_SINGLE = 2'd1,
        FMT_HALF   = 2'd2,
        FMT_BFLOAT = 2'd3
    } fmt_e;

    // Several format bits may be set; the widest one wins, and none set means double.
    function automatic fmt_e fmt_decode(input logic dbl, input logic sgl,
                                        input logic hlf, input logic bf16);
        fmt_e fmt;
        fmt = FMT_DOUBLE;
        if (dbl)       fmt = FMT_DOUBLE;
        else if (sgl)  fmt = FMT_SINGLE;
        else if (hlf)  fmt = FMT_HALF;
        else if (bf16) fmt = FMT_BFLOAT;
        return fmt;
    endfunction

endpackage

// File: rtl/ct_vfdsu_wb_buf_if.sv
// EX4 push side and writeback pop side of the VFDSU result buffer.
// slave = the buffer itself; master = pipeline control plus writeback arbiter.
interface ct_vfdsu_wb_buf_if;

    logic        rtu_yy_xx_flush;
    logic        ex4_out_vld;
    logic [63:0] ex4_out_result;
    logic [4:0]  ex4_out_expt;
    logic [6:0]  ex4_dst_vreg;
    logic [4:0]  ex4_dst_ereg;
    logic [6:0]  ex4_iid;
    logic        ex4_double;
    logic        ex4_single;
    logic        ex4_half;
    logic        ex4_bfloat;
    logic        wbbuf_ex4_ready;

    logic        wb_vld;
    logic        wb_ready;
    logic [63:0] wb_freg_data;
    logic [4:0]  wb_ereg_data;
    logic [6:0]  wb_vreg;
    logic [4:0]  wb_ereg;
    logic [6:0]  wb_iid;

    modport slave (
        input  rtu_yy_xx_flush, ex4_out_vld, ex4_out_result, ex4_out_expt,
               ex4_dst_vreg, ex4_dst_ereg, ex4_iid,
               ex4_double, ex4_single, ex4_half, ex4_bfloat, wb_ready,
        output wbbuf_ex4_ready, wb_vld, wb_freg_data, wb_ereg_data,
               wb_vreg, wb_ereg, wb_iid
    );

    modport master (
        output rtu_yy_xx_flush, ex4_out_vld, ex4_out_result, ex4_out_expt,
               ex4_dst_vreg, ex4_dst_ereg, ex4_iid,
               ex4_double, ex4_single, ex4_half, ex4_bfloat, wb_ready,
        input  wbbuf_ex4_ready, wb_vld, wb_freg_data, wb_ereg_data,
               wb_vreg, wb_ereg, wb_iid
    );

endinterface

// File: rtl/ct_vfdsu_nanbox.sv
// Combinational NaN-boxing of a narrow FP result into a 64-bit register value.
// Zero latency; no state, no backpressure.
module ct_vfdsu_nanbox
    import ct_vfdsu_pkg::*;
(
    input  logic [63:0] result,
    input  logic        fmt_double,
    input  logic        fmt_single,
    input  logic        fmt_half,
    input  logic        fmt_bfloat,
    output logic [63:0] boxed
);

    fmt_e fmt;

    always_comb begin
        fmt   = fmt_decode(fmt_double, fmt_single, fmt_half, fmt_bfloat);
        boxed = result;
        case (fmt)
            FMT_SINGLE: boxed = {NANBOX_S, result[31:0]};
            FMT_HALF,
            FMT_BFLOAT: boxed = {NANBOX_H, result[15:0]};
            default:    boxed = result;
        endcase
    end

endmodule

// File: rtl/ct_vfdsu_wb_buf.sv
// Two-entry in-order VFDSU result buffer (EX4 -> FP/vector writeback), 1-cycle push-to-head latency, no bypass.
// Backpressure: ready drops only when full and wb_ready is low; VFDSU_WBBUF_NANBOX_EN enables NaN-boxing on write.
module ct_vfdsu_wb_buf
    import ct_vfdsu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              forever_cpuclk,
    input  logic              cpurst_b,
    ct_vfdsu_wb_buf_if.slave  bus
);

    wb_entry_t   entry_q [DEPTH];
    logic        wr_ptr_q;
    logic        rd_ptr_q;
    logic [1:0]  cnt_q;

    logic        full;
    logic        push;
    logic        pop;
    logic [63:0] wr_data;
    wb_entry_t   wr_entry;
    wb_entry_t   head;

`ifdef VFDSU_WBBUF_NANBOX_EN
    ct_vfdsu_nanbox u_nanbox (
        .result     (bus.ex4_out_result),
        .fmt_double (bus.ex4_double),
        .fmt_single (bus.ex4_single),
        .fmt_half   (bus.ex4_half),
        .fmt_bfloat (bus.ex4_bfloat),
        .boxed      (wr_data)
    );
`else
    logic unused_fmt;
    assign unused_fmt = ^{bus.ex4_double, bus.ex4_single, bus.ex4_half, bus.ex4_bfloat};
    assign wr_data    = bus.ex4_out_result;
`endif

    // A full buffer still accepts a push in the cycle its head drains.
    assign full                = (cnt_q == 2'(DEPTH));
    assign bus.wbbuf_ex4_ready = !full || bus.wb_ready;
    assign push                = bus.ex4_out_vld && bus.wbbuf_ex4_ready;
    assign pop                 = bus.wb_vld && bus.wb_ready;

    always_comb begin
        wr_entry      = '0;
        wr_entry.data = wr_data;
        wr_entry.expt = bus.ex4_out_expt;
        wr_entry.vreg = bus.ex4_dst_vreg;
        wr_entry.ereg = bus.ex4_dst_ereg;
        wr_entry.iid  = bus.ex4_iid;
    end

    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            cnt_q    <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
        end else if (bus.rtu_yy_xx_flush) begin
            // Flush only rewinds control; stale entry contents are never visible with cnt = 0.
            cnt_q    <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            if (push) begin
                entry_q[wr_ptr_q] <= wr_entry;
                wr_ptr_q          <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign head             = entry_q[rd_ptr_q];
    assign bus.wb_vld       = (cnt_q != 2'd0);
    assign bus.wb_freg_data = head.data;
    assign bus.wb_ereg_data = head.expt;
    assign bus.wb_vreg      = head.vreg;
    assign bus.wb_ereg      = head.ereg;
    assign bus.wb_iid       = head.iid;

endmodule

// File: doc/ct_vfdsu_wb_buf.md
# ct_vfdsu_wb_buf

Two-entry in-order result buffer between the VFDSU EX4 stage and the FP/vector register-file writeback arbiter. Each cycle the divide/sqrt datapath presents a result, it captures the result data, exception flags, destination registers and IID. It then holds them until the writeback port accepts them, and NaN-boxes narrow-format results on the way in. It decouples the iterative divider from writeback-port back-pressure, and its `ready` output feeds the VFDSU pipedown control.

## Interface
Parameters:
- DEPTH, 2, number of buffer entries; fixed at 2, so pointers are 1 bit and the count is 2 bits.

Ports:
- forever_cpuclk  in  1  clock; the single clock.
- cpurst_b  in  1  reset; synchronous and active-low.
- rtu_yy_xx_flush  in  1  pipeline flush; empties the buffer.
- ex4_out_vld  in  1  EX4 result valid for one cycle.
- ex4_out_result  in  64  raw result.
- ex4_out_expt  in  5  fflags {NV,DZ,OF,UF,NX}.
- ex4_dst_vreg  in  7  destination vreg.
- ex4_dst_ereg  in  5  destination ereg.
- ex4_iid  in  7  instruction ID.
- ex4_double, ex4_single, ex4_half, ex4_bfloat  in  1 each  result format.
- wbbuf_ex4_ready  out  1  the buffer can accept a push this cycle.
- wb_vld  out  1  head entry valid.
- wb_ready  in  1  arbiter accepts the head entry.
- wb_freg_data  out  64  head result.
- wb_ereg_data  out  5  head fflags.
- wb_vreg  out  7  head vreg.
- wb_ereg  out  5  head ereg.
- wb_iid  out  7  head IID.

## Operation
- State: entry[1:0] {data, expt, vreg, ereg, iid}, wr_ptr, rd_ptr, cnt in 0..2.
- push = ex4_out_vld & wbbuf_ex4_ready.
- pop = wb_vld & wb_ready.
- wbbuf_ex4_ready = (cnt != 2) | wb_ready.
  - This is combinational from wb_ready.
  - When full, a push is accepted only together with a pop.
- ex4_out_vld while wbbuf_ex4_ready = 0 is a protocol violation: the result is dropped and the state is unchanged.
- Push writes entry[wr_ptr] and toggles wr_ptr. Pop toggles rd_ptr.
- cnt update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Pointers wrap modulo 2.
- wb_vld = (cnt != 0). The wb_* data outputs come from entry[rd_ptr].
- Ordering is strictly FIFO.
- Format select is a priority decode when several bits are set: double > single > half > bfloat. With no bit set, the result is treated as double.
- Flush: cnt, wr_ptr and rd_ptr are cleared.
  - Flush has priority over push and pop in the same cycle; the push is dropped and wb_ready is ignored.
  - Entry contents are not cleared by flush.
- Reset (cpurst_b = 0 at a clock edge): cnt, pointers and all entry fields are set to 0. Reset mid-operation discards all entries.
- Reset values of outputs:
  - wb_vld = 0.
  - wb_freg_data = 0, wb_ereg_data = 0, wb_vreg = 0, wb_ereg = 0, wb_iid = 0.
  - wbbuf_ex4_ready = 1.

## Timing
- Latency: a push at edge N makes wb_vld = 1 from cycle N+1. There is no same-cycle bypass.
- Pop and push in the same cycle at cnt = 1: the old head leaves, the new entry becomes the head at N+1, and wb_vld stays 1.
- Back-to-back pushes with wb_ready held 1 give one writeback per cycle.
- Steady state never exceeds cnt = 1.
- wb_* outputs are stable while wb_vld = 1 and wb_ready = 0.

## Configuration
Macro: VFDSU_WBBUF_NANBOX_EN.
- Defined: the stored data is NaN-boxed by format.
  - single: {32'hFFFF_FFFF, r[31:0]}.
  - half or bfloat: {48'hFFFF_FFFF_FFFF, r[15:0]}.
  - double: r unchanged.
- Undefined: ex4_out_result is stored unchanged.
  - The format inputs remain ports but are unused.

## Structure
- Shared package ct_vfdsu_pkg holds:
  - a typedef for the entry struct {data[63:0], expt[4:0], vreg[6:0], ereg[4:0], iid[6:0]};
  - the NaN-box fill constants NANBOX_S = 32'hFFFF_FFFF and NANBOX_H = 48'hFFFF_FFFF_FFFF.
- One natural sub-module: ct_vfdsu_nanbox, a combinational format decode plus box applied before the write. It is instantiated only under the macro.
- FIFO control stays in the top module.

## Test plan
- Single push, result 64'h0000_0000_3F80_0000, ex4_single, wb_ready = 1, macro on: wb_vld = 1 one cycle later, wb_freg_data = 64'hFFFF_FFFF_3F80_0000, then cnt = 0.
- Two pushes with wb_ready = 0:
  - wbbuf_ex4_ready = 0 after the second push.
  - A third ex4_out_vld is dropped.
  - Raising wb_ready pops IIDs in push order (5, then 6).
- Full buffer, simultaneous push and pop: push accepted, cnt stays 2, and the head advances from IID 5 to IID 6.
- Flush asserted together with push at cnt = 1: cnt = 0 next cycle, wb_vld = 0, and the pushed IID never appears.
- Mid-operation reset (cpurst_b = 0 with cnt = 2): all wb_* = 0, wb_vld = 0 and wbbuf_ex4_ready = 1 on the next cycle.
- Macro off, ex4_half with result 64'h0000_0000_0000_3C00: wb_freg_data = 64'h0000_0000_0000_3C00.
